// File: rtl/conv1d_obi_burst_reader.sv
// OBI read-burst engine: issues sequential word reads and buffers the responses in a small FIFO.
// Optional protocol checker is compiled in when CONV1D_OBI_RD_PROT_CHECK_EN is defined.
package conv1d_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module conv1d_obi_burst_reader #(
    parameter type         obi_req_t  = conv1d_obi_pkg::obi_req_t,
    parameter type         obi_resp_t = conv1d_obi_pkg::obi_resp_t,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output obi_req_t         obi_req_o,
    input  obi_resp_t        obi_rsp_i,
    output logic [31:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             err_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issued;
    logic [LEN_W-1:0] r_popped;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic             r_done;

    logic             w_req;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [CW:0]      w_occupancy;

    // Requests in flight plus buffered words never exceed the FIFO, so every response has a slot.
    assign w_occupancy = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req       = (r_state == ISSUE) && (r_issued < r_len)
                         && (w_occupancy < (CW + 1)'(FIFO_DEPTH));
    assign w_accept    = w_req && obi_rsp_i.gnt;
    assign w_push      = obi_rsp_i.rvalid && (r_outstanding != '0);
    assign w_pop       = valid_o && ready_i;

    always_comb begin
        obi_req_o       = '0;
        obi_req_o.req   = w_req;
        obi_req_o.we    = 1'b0;
        obi_req_o.be    = 4'hF;
        obi_req_o.addr  = r_addr;
        obi_req_o.wdata = '0;
    end

    assign valid_o = (r_count != '0);
    assign data_o  = r_mem[r_rptr];
    assign busy_o  = (r_state != IDLE);
    assign done_o  = r_done;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= obi_rsp_i.rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_popped      <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case ({w_accept, w_push})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);

            if (w_accept) begin
                r_addr   <= r_addr + 32'd4;
                r_issued <= r_issued + LEN_W'(1);
            end
            if (w_pop) r_popped <= r_popped + LEN_W'(1);

            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_addr   <= base_addr_i;
                            r_len    <= len_i;
                            r_issued <= '0;
                            r_popped <= '0;
                            r_state  <= ISSUE;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (w_accept && (r_issued == r_len - LEN_W'(1))) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_pop && (r_popped == r_len - LEN_W'(1)) && (r_outstanding == '0)) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CONV1D_OBI_RD_PROT_CHECK_EN
    logic        r_err;
    logic        r_stalled;
    logic [31:0] r_stall_addr;

    // A stalled request must hold both req and addr until it is granted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err        <= 1'b0;
            r_stalled    <= 1'b0;
            r_stall_addr <= '0;
        end else begin
            r_stalled    <= w_req && !obi_rsp_i.gnt;
            r_stall_addr <= r_addr;
            if ((obi_rsp_i.rvalid && (r_outstanding == '0))
                || (r_stalled && (!w_req || (r_addr != r_stall_addr)))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_conv1d_obi_burst_reader.sv
// Self-checking bench for conv1d_obi_burst_reader: randomized OBI memory/consumer against a
// word-list reference model (addr = base + 4*i, data = memory contents at that addr).
module tb_conv1d_obi_burst_reader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, valid, err;
    logic        ready = 1'b0;
    logic [31:0] data;
    conv1d_obi_pkg::obi_req_t  req_s;
    conv1d_obi_pkg::obi_resp_t rsp_s = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;

    int          gnt_mode = 0;   // 0: always granted, 1: random
    int          gnt_hold = 0;   // cycles with req=1 to withhold gnt
    int          ready_mode = 1; // 0: low, 1: high, 2: random
    bit          rv_rand = 1'b0;
    bit          spur = 1'b0;
    logic [31:0] seed = '0;

    logic [31:0] acc_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] got_q[$];
    int          done_q[$];
    int          busy_cnt = 0;
    int          stab_fail = 0;
    int          ovf_fail = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

`ifdef CONV1D_OBI_RD_PROT_CHECK_EN
    localparam logic EXP_SPUR_ERR = 1'b1;
`else
    localparam logic EXP_SPUR_ERR = 1'b0;
`endif

    conv1d_obi_burst_reader #(
        .FIFO_DEPTH(DEPTH),
        .LEN_W     (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .base_addr_i(base_addr),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .obi_req_o  (req_s),
        .obi_rsp_i  (rsp_s),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .err_o      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return seed ^ (32'hA0 + ((a - 32'h100) >> 2));
    endfunction

    // Monitor: mid-cycle sampling of handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_s.req && rsp_s.gnt) begin
                acc_q.push_back(req_s.addr);
                pend_q.push_back(req_s.addr);
            end
            if (prev_stall && (!req_s.req || req_s.addr != prev_addr)) stab_fail++;
            prev_stall = req_s.req && !rsp_s.gnt;
            prev_addr  = req_s.addr;
            if (valid && ready) got_q.push_back(data);
            if (done) done_q.push_back(cyc);
            if (busy) busy_cnt++;
            if (acc_q.size() > got_q.size() + DEPTH) ovf_fail++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Memory/consumer model driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        rsp_s.gnt = (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (gnt_hold > 0) begin
            rsp_s.gnt = 1'b0;
            if (req_s.req) gnt_hold--;
        end
        if (spur) begin
            rsp_s.rvalid = 1'b1;
            rsp_s.rdata  = 32'hDEADBEEF;
            spur = 1'b0;
        end else if (rst_n && pend_q.size() > 0 && (!rv_rand || $urandom_range(0, 2) != 0)) begin
            rsp_s.rvalid = 1'b1;
            rsp_s.rdata  = mem_val(pend_q.pop_front());
        end else begin
            rsp_s.rvalid = 1'b0;
            rsp_s.rdata  = '0;
        end
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic clear_logs();
        acc_q.delete();
        got_q.delete();
        done_q.delete();
        busy_cnt  = 0;
        stab_fail = 0;
        ovf_fail  = 0;
    endtask

    task automatic start_burst(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk);
        #1;
        base_addr = b;
        len       = n;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0)     begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (req_s.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req_s.req); end
        checks++; if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        gnt_mode = 0; rv_rand = 1'b0; ready_mode = 1; seed = '0;
        clear_logs();
        start_burst(32'h100, 16'd4);
        wait_done(50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
        checks++;
        if (done_q.size() != 1 || done_q[0] - start_cyc != 7) begin
            failures++; $display("FAIL basic_done_cycle got=%0d exp=7", (done_q.size() > 0) ? done_q[0] - start_cyc : -1);
        end
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ea, ed;
            ea = 32'h100 + 32'(4 * i);
            ed = 32'hA0 + 32'(i);
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== ea) begin failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, acc_q[i], ea); end
            checks++;
            if (i >= got_q.size() || got_q[i] !== ed) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got_q[i], ed); end
        end
    endtask

    task automatic test_len0();
        clear_logs();
        start_burst(32'h40, 16'd0);
        repeat (4) @(negedge clk);
        checks++; if (done_q.size() != 1) begin failures++; $display("FAIL len0_done_count got=%0d exp=1", done_q.size()); end
        checks++;
        if (done_q.size() == 0 || done_q[0] - start_cyc != 1) begin
            failures++; $display("FAIL len0_done_cycle got=%0d exp=1", (done_q.size() > 0) ? done_q[0] - start_cyc : -1);
        end
        checks++; if (acc_q.size() != 0) begin failures++; $display("FAIL len0_reqs got=%0d exp=0", acc_q.size()); end
        checks++; if (busy_cnt != 0) begin failures++; $display("FAIL len0_busy got=%0d exp=0", busy_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] exp_a [3];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
        seed = $urandom;
        clear_logs();
        start_burst(32'hFFFF_FFF8, 16'd3);
        wait_done(50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=no_done exp=done"); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, acc_q[i], exp_a[i]); end
            checks++;
            if (i >= got_q.size() || got_q[i] !== mem_val(exp_a[i])) begin
                failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, got_q[i], mem_val(exp_a[i]));
            end
        end
    endtask

    task automatic test_gnt_stall();
        bit ok;
        logic [31:0] b;
        b = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        seed = $urandom;
        gnt_hold = 3;
        clear_logs();
        start_burst(b, 16'd5);
        @(posedge clk); #1;
        base_addr = 32'h0; len = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(80, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=no_done exp=done"); end
        checks++; if (gnt_hold != 0) begin failures++; $display("FAIL stall_hold_used got=%0d exp=0", gnt_hold); end
        checks++; if (stab_fail != 0) begin failures++; $display("FAIL stall_stability got=%0d exp=0", stab_fail); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL stall_err got=%b exp=0", err); end
        checks++; if (got_q.size() != 5) begin failures++; $display("FAIL stall_count got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            logic [31:0] ea;
            ea = b + 32'(4 * i);
            checks++;
            if (i >= got_q.size() || got_q[i] !== mem_val(ea) || acc_q[i] !== ea) begin
                failures++; $display("FAIL stall_word[%0d] got=%h@%h exp=%h@%h", i, got_q[i], acc_q[i], mem_val(ea), ea);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] b;
        b = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        seed = $urandom;
        ready_mode = 0;
        clear_logs();
        start_burst(b, 16'd8);
        repeat (20) @(negedge clk);
        checks++; if (acc_q.size() != DEPTH) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", acc_q.size(), DEPTH); end
        checks++; if (req_s.req !== 1'b0) begin failures++; $display("FAIL bp_req_low got=%b exp=0", req_s.req); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", valid); end
        ready_mode = 1;
        wait_done(80, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
        checks++; if (ovf_fail != 0) begin failures++; $display("FAIL bp_overflow got=%0d exp=0", ovf_fail); end
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ea;
            ea = b + 32'(4 * i);
            checks++;
            if (i >= got_q.size() || got_q[i] !== mem_val(ea) || acc_q[i] !== ea) begin
                failures++; $display("FAIL bp_word[%0d] got=%h@%h exp=%h@%h", i, got_q[i], acc_q[i], mem_val(ea), ea);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        logic [31:0] b;
        gnt_mode = 1; rv_rand = 1'b1; ready_mode = 2;
        for (int it = 0; it < 8; it++) begin
            seed = $urandom;
            n = $urandom_range(1, 12);
            b = (it == 3) ? 32'hFFFF_FFF0 : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            clear_logs();
            start_burst(b, 16'(n));
            wait_done(400, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rand%0d_timeout got=no_done exp=done", it); end
            checks++; if (done_q.size() != 1) begin failures++; $display("FAIL rand%0d_done_count got=%0d exp=1", it, done_q.size()); end
            checks++; if (got_q.size() != n || acc_q.size() != n) begin
                failures++; $display("FAIL rand%0d_count got=%0d/%0d exp=%0d", it, got_q.size(), acc_q.size(), n);
            end
            checks++; if (stab_fail != 0 || ovf_fail != 0) begin
                failures++; $display("FAIL rand%0d_protocol got=%0d/%0d exp=0/0", it, stab_fail, ovf_fail);
            end
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL rand%0d_err got=%b exp=0", it, err); end
            for (int i = 0; i < n; i++) begin
                logic [31:0] ea;
                ea = b + 32'(4 * i);
                checks++;
                if (i >= got_q.size() || i >= acc_q.size() || got_q[i] !== mem_val(ea) || acc_q[i] !== ea) begin
                    failures++; $display("FAIL rand%0d_word[%0d] got=%h@%h exp=%h@%h", it, i, got_q[i], acc_q[i], mem_val(ea), ea);
                end
            end
        end
        gnt_mode = 0; rv_rand = 1'b0; ready_mode = 1;
    endtask

    task automatic test_reset_mid();
        gnt_mode = 0; rv_rand = 1'b0; ready_mode = 1;
        clear_logs();
        start_burst(32'h2000, 16'd8);
        @(negedge clk);
        rst_n = 1'b0;
        pend_q.delete();
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0)     begin failures++; $display("FAIL rmid_valid got=%b exp=0", valid); end
        checks++; if (req_s.req !== 1'b0) begin failures++; $display("FAIL rmid_req got=%b exp=0", req_s.req); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL rmid_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0)       begin failures++; $display("FAIL rmid_err got=%b exp=0", err); end
        pend_q.delete();
        got_q.delete();
        rst_n = 1'b1;
        spur  = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL spur_valid got=%b exp=0", valid); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL spur_dropped got=%0d exp=0", got_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_busy got=%b exp=0", busy); end
        checks++; if (err !== EXP_SPUR_ERR) begin failures++; $display("FAIL spur_err got=%b exp=%b", err, EXP_SPUR_ERR); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_gnt_stall();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv1d_obi_burst_reader.md
CONV1D_OBI_BURST_READER -- requirements
Module: conv1d_obi_burst_reader

Interface
REQ-001 SHALL have parameter obi_req_t, default conv1d_obi_pkg::obi_req_t, OBI request struct (req, we, be, addr, wdata).
REQ-002 SHALL have parameter obi_resp_t, default conv1d_obi_pkg::obi_resp_t, OBI response struct (gnt, rvalid, rdata).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, read-data buffer entries (power of two, >=2).
REQ-004 SHALL have parameter LEN_W, default 16, width of the burst length.
REQ-005 SHALL have ports (one clock; reset synchronous, active-low):
  clk_i  in  1  clock
  rst_ni  in  1  synchronous active-low reset
  start_i  in  1  start burst, sampled in IDLE only
  base_addr_i  in  32  byte address of first word, sampled with start_i
  len_i  in  LEN_W  number of 32-bit words, sampled with start_i
  busy_o  out  1  burst in progress
  done_o  out  1  one-cycle pulse when the last word has left the FIFO
  obi_req_o  out  obi_req_t  OBI request to memory adapter
  obi_rsp_i  in  obi_resp_t  OBI response from memory adapter
  data_o  out  32  read word to consumer
  valid_o  out  1  data_o valid
  ready_i  in  1  consumer accepts data_o
  err_o  out  1  sticky protocol-error flag (see Configuration)

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-007 IDLE: start_i=1 with len_i>0 SHALL latch base_addr_i/len_i and go to ISSUE next cycle; start_i with len_i=0 SHALL pulse done_o next cycle and stay IDLE.
REQ-008 start_i outside IDLE SHALL be ignored.
REQ-009 ISSUE: obi_req_o.req SHALL be 1 iff issued<len and (outstanding + fifo_count) < FIFO_DEPTH; we=0, be=4'hF, wdata=0 always.
REQ-010 A request SHALL be accepted when req and gnt are both 1 in the same cycle; addr SHALL then advance by 4 (wrapping modulo 2^32); req/addr SHALL stay stable while req=1 and gnt=0.
REQ-011 Outstanding counter SHALL +1 on accept, -1 on rvalid, unchanged when both occur in the same cycle.
REQ-012 On rvalid, rdata SHALL be written into the FIFO the same edge; FIFO SHALL never overflow by construction of REQ-009.
REQ-013 ISSUE SHALL go to DRAIN in the cycle after the len-th accept.
REQ-014 DRAIN: on the cycle the len-th word is popped (valid_o & ready_i) with outstanding=0, FSM SHALL go IDLE and done_o SHALL pulse in the next cycle.
REQ-015 valid_o SHALL equal (fifo_count != 0); data_o SHALL be the FIFO head; pop and push in the same cycle SHALL keep count unchanged, including at full and empty.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; data order SHALL equal request order.
REQ-017 busy_o SHALL be 1 in ISSUE and DRAIN, 0 in IDLE.
REQ-018 Latency: with gnt tied 1, rvalid one cycle after accept, ready_i=1: first valid_o 2 cycles after start_i; N words complete in N+2 cycles, done_o at cycle N+3.

Reset
REQ-019 With rst_ni=0 at a rising edge: FSM=IDLE, counters/pointers=0, obi_req_o.req=0, valid_o=0, busy_o=0, done_o=0, err_o=0.
REQ-020 Reset mid-burst SHALL discard FIFO contents and outstanding count; rvalid arriving after reset with no outstanding request SHALL be dropped (and flagged per REQ-021 if enabled).

Configuration
REQ-021 With CONV1D_OBI_RD_PROT_CHECK_EN defined: err_o SHALL set (sticky until reset) when rvalid=1 and outstanding=0, or when obi_req_o.addr/req change while req=1 and gnt=0.
REQ-022 Without CONV1D_OBI_RD_PROT_CHECK_EN: err_o SHALL be constant 0 and no checker logic synthesized.

Verification
REQ-023 gnt=1, 1-cycle rvalid, ready=1, base=0x100, len=4, mem[i]=0xA0+i -> data 0xA0..0xA3 in order, addrs 0x100..0x10C, done_o at cycle 7.
REQ-024 len=0 start -> no obi req, done_o one cycle later, busy_o stays 0.
REQ-025 ready_i=0, len=8, FIFO_DEPTH=4 -> at most 4 requests accepted, req drops, no overflow; release ready -> all 8 words correct.
REQ-026 gnt held 0 for 3 cycles on first request -> addr/req stable, err_o=0, burst completes correctly.
REQ-027 base=0xFFFF_FFF8, len=3 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-028 rst_ni=0 mid-burst, then spurious rvalid -> outputs at reset values, data dropped; err_o=1 only with CONV1D_OBI_RD_PROT_CHECK_EN.
